// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock timekeeping controller.
// Optional feature macro: CLOCK_ALARM_EN (adds the alarm-set states).
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MODE_W = 3;

    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;

    // Encodings are visible on the mode output and drive display blinking.
    typedef enum logic [MODE_W-1:0] {
        RUN         = 3'd0,
        SET_HOUR    = 3'd1,
        SET_MIN     = 3'd2,
`ifdef CLOCK_ALARM_EN
        SET_SEC     = 3'd3,
        SET_AL_HOUR = 3'd4,
        SET_AL_MIN  = 3'd5
`else
        SET_SEC     = 3'd3
`endif
    } mode_e;

    // Hour increment with 23 -> 0 wrap.
    function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] v);
        return (v == HOUR_MAX) ? '0 : v + 1'b1;
    endfunction

    // Minute/second increment with 59 -> 0 wrap.
    function automatic logic [MIN_W-1:0] inc_sixty(input logic [MIN_W-1:0] v);
        return (v == MIN_MAX) ? '0 : v + 1'b1;
    endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Button inputs and time/display outputs of the timekeeping controller.
// Optional feature macro: CLOCK_ALARM_EN (alarm_out is 0 without it).
interface clock_time_ctrl_if;
    import clock_pkg::*;

    logic              btn_mode;
    logic              btn_inc;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MODE_W-1:0] mode;
    logic              sec_pulse;
    logic              alarm_out;

    // Button/debounce side drives the buttons and observes the time.
    modport master (
        output btn_mode, btn_inc,
        input  hour, min, sec, mode, sec_pulse, alarm_out
    );

    // The controller itself.
    modport slave (
        input  btn_mode, btn_inc,
        output hour, min, sec, mode, sec_pulse, alarm_out
    );
endinterface

// File: rtl/clock_tick_gen.sv
// 1 Hz prescaler: counts 0..CLK_HZ-1 while run_en is high and flags the
// wrap cycle with tick; held at 0 whenever run_en is low.
module clock_tick_gen #(
    parameter int CLK_HZ = 50000000,
    parameter int CNT_W  = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic run_en,
    output logic tick
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = run_en && (cnt == CNT_LAST);

    // Prescaler counter; restarts from 0 on every entry into RUN.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of block evaluation order.
        if (reset)
            cnt <= '0;
        else if (!run_en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: time-of-day counters, time-set state machine and
// optional alarm. Optional feature macro: CLOCK_ALARM_EN.
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int CNT_W  = 26
) (
    input  logic               clk,
    input  logic               reset,
    clock_time_ctrl_if.slave   bus
);
    mode_e             state, state_nxt;
    logic              run_en, tick, inc_ok;
    logic [HOUR_W-1:0] hour_q, hour_nxt;
    logic [MIN_W-1:0]  min_q, min_nxt;
    logic [SEC_W-1:0]  sec_q, sec_nxt;
    logic              sec_pulse_q;

    assign run_en = (state == RUN);
    // btn_mode wins over a simultaneous btn_inc.
    assign inc_ok = bus.btn_inc && !bus.btn_mode;

    clock_tick_gen #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .run_en (run_en),
        .tick   (tick)
    );

    // Mode state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    // Mode sequencing on btn_mode.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        state_nxt = state;
        if (bus.btn_mode) begin
            case (state)
                RUN:         state_nxt = SET_HOUR;
                SET_HOUR:    state_nxt = SET_MIN;
                SET_MIN:     state_nxt = SET_SEC;
`ifdef CLOCK_ALARM_EN
                SET_SEC:     state_nxt = SET_AL_HOUR;
                SET_AL_HOUR: state_nxt = SET_AL_MIN;
`endif
                default:     state_nxt = RUN;
            endcase
        end
    end

    // Next time value: tick with carry in RUN, isolated field increment in SET.
    always_comb begin
        hour_nxt = hour_q;
        min_nxt  = min_q;
        sec_nxt  = sec_q;
        if (tick) begin
            sec_nxt = inc_sixty(sec_q);
            if (sec_q == SEC_MAX) begin
                min_nxt = inc_sixty(min_q);
                if (min_q == MIN_MAX)
                    hour_nxt = inc_hour(hour_q);
            end
        end else if (inc_ok) begin
            case (state)
                SET_HOUR: hour_nxt = inc_hour(hour_q);
                SET_MIN:  min_nxt  = inc_sixty(min_q);
                SET_SEC:  sec_nxt  = inc_sixty(sec_q);
                default:  ;
            endcase
        end
    end

    // Time registers and the per-second pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            sec_pulse_q <= 1'b0;
        end else begin
            hour_q      <= hour_nxt;
            min_q       <= min_nxt;
            sec_q       <= sec_nxt;
            sec_pulse_q <= tick;
        end
    end

    assign bus.hour      = hour_q;
    assign bus.min       = min_q;
    assign bus.sec       = sec_q;
    assign bus.mode      = state;
    assign bus.sec_pulse = sec_pulse_q;

`ifdef CLOCK_ALARM_EN
    logic [HOUR_W-1:0] al_hour_q;
    logic [MIN_W-1:0]  al_min_q;
    logic              alarm_q;
    logic [5:0]        al_ticks_q;
    logic              al_match;

    assign al_match = tick && (sec_nxt == '0) && (min_nxt == al_min_q)
                      && (hour_nxt == al_hour_q);

    // Alarm time registers, set with btn_inc in the alarm-set states.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            al_hour_q <= '0;
            al_min_q  <= '0;
        end else if (inc_ok && state == SET_AL_HOUR) begin
            al_hour_q <= inc_hour(al_hour_q);
        end else if (inc_ok && state == SET_AL_MIN) begin
            al_min_q  <= inc_sixty(al_min_q);
        end
    end

    // Alarm flag: raised on the matching tick, dropped on dismiss, on leaving
    // RUN, or on the 60th tick after it was raised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_q    <= 1'b0;
            al_ticks_q <= '0;
        end else if (!run_en || bus.btn_mode || bus.btn_inc) begin
            alarm_q    <= 1'b0;
            al_ticks_q <= '0;
        end else if (al_match) begin
            alarm_q    <= 1'b1;
            al_ticks_q <= '0;
        end else if (tick && alarm_q) begin
            if (al_ticks_q == 6'd59)
                alarm_q <= 1'b0;
            al_ticks_q <= al_ticks_q + 1'b1;
        end
    end

    assign bus.alarm_out = alarm_q;
`else
    assign bus.alarm_out = 1'b0;
`endif
endmodule
